// File: rtl/coord_to_note_in.sv
// Encodes bar/slot hit coordinates into a 30-bit multi-hot note vector, merges
// hits over a WINDOW-cycle collection window and presents the result with valid/ack.
module coord_to_note_in #(
  parameter int unsigned WINDOW = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        hit_valid,
  input  logic [2:0]  hit_x,
  input  logic [2:0]  hit_y,
  input  logic        note_ack,
  output logic [31:0] note_in,
  output logic        note_valid,
  output logic        bad_coord,
  output logic [7:0]  hit_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam logic [15:0] LAST = 16'(WINDOW - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [29:0] acc_q, acc_d;
  logic [31:0] note_q, note_d;
  logic        valid_q, valid_d;
  logic        bad_q, bad_d;
  logic [7:0]  hc_q, hc_d;

  logic        legal;
  logic        accept;
  logic [4:0]  idx;
  logic [29:0] hit_vec;
  logic [29:0] acc_merged;

  assign legal      = (hit_x <= 3'd4) && (hit_y <= 3'd5);
  assign accept     = hit_valid && legal;
  assign idx        = {2'b00, hit_x} * 5'd6 + {2'b00, hit_y};
  assign hit_vec    = accept ? (30'd1 << idx) : '0;
  // Hits sampled in the same cycle as a window expiry or an ack are folded in here.
  assign acc_merged = acc_q | hit_vec;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_merged;
    note_d  = note_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = COLLECT;
          cnt_d   = '0;
        end
      end
      COLLECT: begin
        if (cnt_q == LAST) begin
          state_d = PRESENT;
          note_d  = {2'b00, acc_merged};
          valid_d = 1'b1;
          acc_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      PRESENT: begin
        if (note_ack) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = (|acc_merged) ? COLLECT : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bad_d = hit_valid && !legal;
  assign hc_d  = (accept && (hc_q != 8'hFF)) ? hc_q + 8'd1 : hc_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      note_q  <= '0;
      valid_q <= 1'b0;
      bad_q   <= 1'b0;
      hc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      note_q  <= note_d;
      valid_q <= valid_d;
      bad_q   <= bad_d;
      hc_q    <= hc_d;
    end
  end

  assign note_in    = note_q;
  assign note_valid = valid_q;
  assign bad_coord  = bad_q;
  assign hit_count  = hc_q;

endmodule

// File: tb/tb_coord_to_note_in.sv
// Directed bench for coord_to_note_in: WINDOW=4 main instance plus a WINDOW=1
// instance for the minimum-latency case.
module tb_coord_to_note_in;

  logic        clock;
  logic        resetn;
  logic        hit_valid, note_ack;
  logic [2:0]  hit_x, hit_y;
  logic [31:0] note_in;
  logic        note_valid, bad_coord;
  logic [7:0]  hit_count;

  logic        h1_valid, h1_ack;
  logic [2:0]  h1_x, h1_y;
  logic [31:0] n1_in;
  logic        n1_valid, n1_bad;
  logic [7:0]  n1_count;

  int tests  = 0;
  int failed = 0;
  int pres   = 0;

  coord_to_note_in #(.WINDOW(4)) u_dut (
    .clock(clock), .resetn(resetn), .hit_valid(hit_valid), .hit_x(hit_x), .hit_y(hit_y),
    .note_ack(note_ack), .note_in(note_in), .note_valid(note_valid),
    .bad_coord(bad_coord), .hit_count(hit_count)
  );

  coord_to_note_in #(.WINDOW(1)) u_dut_w1 (
    .clock(clock), .resetn(resetn), .hit_valid(h1_valid), .hit_x(h1_x), .hit_y(h1_y),
    .note_ack(h1_ack), .note_in(n1_in), .note_valid(n1_valid),
    .bad_coord(n1_bad), .hit_count(n1_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic hit(input logic [2:0] x, input logic [2:0] y);
    hit_valid = 1'b1;
    hit_x     = x;
    hit_y     = y;
  endtask

  task automatic no_hit();
    hit_valid = 1'b0;
    hit_x     = 3'd0;
    hit_y     = 3'd0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    note_ack = 1'b0;
    no_hit();
    h1_valid = 1'b0; h1_x = 3'd0; h1_y = 3'd0; h1_ack = 1'b0;
    tick();
    tick();
    chk("rst_note_in", note_in, 32'h0);
    chk("rst_note_valid", {31'd0, note_valid}, 32'h0);
    chk("rst_bad_coord", {31'd0, bad_coord}, 32'h0);
    chk("rst_hit_count", {24'd0, hit_count}, 32'h0);
    resetn = 1'b1;
    tick();

    // Bad coordinates
    hit(3'd5, 3'd0); tick(); no_hit();
    chk("bad1_pulse", {31'd0, bad_coord}, 32'h1);
    tick();
    chk("bad1_clear", {31'd0, bad_coord}, 32'h0);
    hit(3'd0, 3'd6); tick(); no_hit();
    chk("bad2_pulse", {31'd0, bad_coord}, 32'h1);
    tick();
    chk("bad2_clear", {31'd0, bad_coord}, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("bad_no_valid", {31'd0, note_valid}, 32'h0);
    chk("bad_hit_count", {24'd0, hit_count}, 32'h0);

    // Single hit (2,3) -> bit 15
    hit(3'd2, 3'd3); tick(); no_hit();
    chk("single_hc", {24'd0, hit_count}, 32'd1);
    chk("single_v_e0", {31'd0, note_valid}, 32'h0);
    tick(); tick(); tick();
    chk("single_v_e3", {31'd0, note_valid}, 32'h0);
    tick();
    chk("single_note", note_in, 32'h0000_8000);
    chk("single_v_e4", {31'd0, note_valid}, 32'h1);
    tick();
    chk("single_hold", {31'd0, note_valid}, 32'h1);
    note_ack = 1'b1; tick(); note_ack = 1'b0;
    chk("single_ack_v", {31'd0, note_valid}, 32'h0);
    chk("single_note_kept", note_in, 32'h0000_8000);
    for (int i = 0; i < 6; i++) tick();
    chk("single_idle", {31'd0, note_valid}, 32'h0);

    // Merged hits (0,0) e0, (4,5) e2, (1,0) e3
    hit(3'd0, 3'd0); tick();
    no_hit(); tick();
    hit(3'd4, 3'd5); tick();
    hit(3'd1, 3'd0); tick();
    no_hit();
    chk("merge_v_e3", {31'd0, note_valid}, 32'h0);
    tick();
    chk("merge_note", note_in, 32'h2000_0041);
    chk("merge_v_e4", {31'd0, note_valid}, 32'h1);
    chk("merge_hc", {24'd0, hit_count}, 32'd4);
    note_ack = 1'b1; tick(); note_ack = 1'b0;
    pres = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (note_valid) pres++;
    end
    chk("merge_single_pres", pres, 0);

    // Pending hit during PRESENT: (3,2) -> bit 20
    hit(3'd0, 3'd0); tick(); no_hit();
    tick(); tick(); tick(); tick();
    chk("pend_first", note_in, 32'h0000_0001);
    pres = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) hit(3'd3, 3'd2); else no_hit();
      tick();
      if (note_in !== 32'h0000_0001 || note_valid !== 1'b1) pres++;
    end
    no_hit();
    chk("pend_hold_stable", pres, 0);
    note_ack = 1'b1; tick(); note_ack = 1'b0;
    chk("pend_ack_v", {31'd0, note_valid}, 32'h0);
    tick(); tick(); tick();
    chk("pend_gap", {31'd0, note_valid}, 32'h0);
    tick();
    chk("pend_second_v", {31'd0, note_valid}, 32'h1);
    chk("pend_second_note", note_in, 32'h0010_0000);
    note_ack = 1'b1; tick(); note_ack = 1'b0;
    chk("pend_second_ack", {31'd0, note_valid}, 32'h0);
    tick(); tick();

    // Asynchronous reset mid-COLLECT
    hit(3'd1, 3'd1); tick(); no_hit(); tick();
    #2 resetn = 1'b0;
    #1;
    chk("rstc_note", note_in, 32'h0);
    chk("rstc_hc", {24'd0, hit_count}, 32'h0);
    chk("rstc_v", {31'd0, note_valid}, 32'h0);
    tick(); resetn = 1'b1;
    pres = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (note_valid) pres++;
    end
    chk("rstc_no_pres", pres, 0);

    // Asynchronous reset while presenting
    hit(3'd2, 3'd0); tick(); no_hit();
    tick(); tick(); tick(); tick();
    chk("rstp_pre_v", {31'd0, note_valid}, 32'h1);
    chk("rstp_pre_note", note_in, 32'h0000_1000);
    #3 resetn = 1'b0;
    #1;
    chk("rstp_note", note_in, 32'h0);
    chk("rstp_v", {31'd0, note_valid}, 32'h0);
    chk("rstp_hc", {24'd0, hit_count}, 32'h0);
    tick(); resetn = 1'b1;
    pres = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (note_valid) pres++;
    end
    chk("rstp_no_pres", pres, 0);

    // WINDOW=1 latency
    h1_valid = 1'b1; h1_x = 3'd1; h1_y = 3'd0; tick(); h1_valid = 1'b0;
    chk("w1_v_e0", {31'd0, n1_valid}, 32'h0);
    tick();
    chk("w1_v_e1", {31'd0, n1_valid}, 32'h1);
    chk("w1_note", n1_in, 32'h0000_0040);

    // Saturation and duplicates with ack held high
    do_reset();
    note_ack = 1'b1;
    pres = 0;
    for (int i = 0; i < 300; i++) begin
      hit(3'd0, 3'd0);
      tick();
      if (note_valid) begin
        if (note_in !== 32'h0000_0001) chk("sat_vec", note_in, 32'h0000_0001);
        pres++;
      end
      if (i == 253) chk("sat_hc_254", {24'd0, hit_count}, 32'd254);
      if (i == 254) chk("sat_hc_255", {24'd0, hit_count}, 32'd255);
    end
    no_hit();
    chk("sat_hc_final", {24'd0, hit_count}, 32'd255);
    chk("sat_presented", {31'd0, pres > 50}, 32'h1);
    for (int i = 0; i < 8; i++) tick();
    note_ack = 1'b0;
    chk("sat_drain_idle", {31'd0, note_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
